// File: rtl/conf_reg_bank_db_pkg.sv
// rtl/conf_reg_bank_db_pkg.sv - shared constants and FSM state type for the double-buffered config bank
package conf_reg_bank_db_pkg;

   localparam int CONF_REGISTERS_SIZE     = 32;
   localparam int BIT_WIDTH_EXTERNAL_PORT = 32;

   localparam int MODE_FC         = 0;
   localparam int MODE_CNN        = 1;
   localparam int MODE_ACTIVATION = 2;
   localparam int MODE_EWS        = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      COMMIT = 2'd2,
      START  = 2'd3
   } state_t;

endpackage

// File: rtl/conf_reg_bank_db_byte_strobe_reg.sv
// rtl/conf_reg_bank_db_byte_strobe_reg.sv - register with per-byte write enable and synchronous reset
module byte_strobe_reg
   import conf_reg_bank_db_pkg::*;
#(
   parameter int WIDTH = BIT_WIDTH_EXTERNAL_PORT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [WIDTH/8-1:0] be,
   input  logic [WIDTH-1:0]   d,
   output logic [WIDTH-1:0]   q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         for (int k = 0; k < WIDTH/8; k++) begin
            if (be[k]) q[k*8 +: 8] <= d[k*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/conf_reg_bank_db.sv
// rtl/conf_reg_bank_db.sv - shadow/active configuration bank with idle-gated commit handshake
module conf_reg_bank_db
   import conf_reg_bank_db_pkg::*;
#(
   parameter int N_REGS    = CONF_REGISTERS_SIZE,
   parameter int REG_WIDTH = BIT_WIDTH_EXTERNAL_PORT,
   parameter int ADDR_W    = $clog2(N_REGS),
   parameter int N_MODES   = 4,
   parameter int MODE_BITS = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [REG_WIDTH-1:0]        wr_data,
   input  logic [REG_WIDTH/8-1:0]      wr_be,
   input  logic                        rd_en,
   input  logic [ADDR_W-1:0]           rd_addr,
   input  logic                        rd_sel_active,
   output logic [REG_WIDTH-1:0]        rd_data,
   output logic                        rd_valid,
   input  logic                        commit_req,
   input  logic                        engine_idle,
   output logic                        commit_ack,
   output logic                        layer_start,
   output logic [N_REGS*REG_WIDTH-1:0] cfg_active,
   output logic [MODE_BITS-1:0]        cfg_mode,
   output logic                        cfg_valid,
   output logic                        pending,
   output logic                        addr_err,
   output logic                        mode_err,
   input  logic                        err_clr
);

   localparam logic [ADDR_W:0]    REG_LIMIT  = (ADDR_W+1)'(N_REGS);
   localparam logic [MODE_BITS:0] MODE_LIMIT = (MODE_BITS+1)'(N_MODES);

   logic [REG_WIDTH-1:0] shadow [N_REGS];
   logic [REG_WIDTH-1:0] active [N_REGS];
   state_t               state;
   logic                 req_armed;
   logic                 wr_in_range, rd_in_range, mode_ok;

   assign wr_in_range = ({1'b0, wr_addr} < REG_LIMIT);
   assign rd_in_range = ({1'b0, rd_addr} < REG_LIMIT);
   assign mode_ok     = ({1'b0, shadow[0][MODE_BITS-1:0]} < MODE_LIMIT);

   for (genvar i = 0; i < N_REGS; i++) begin : g_regs
      byte_strobe_reg #(.WIDTH(REG_WIDTH)) u_shadow (
         .clk   (clk),
         .reset (reset),
         .en    (wr_en && wr_in_range && (wr_addr == ADDR_W'(i))),
         .be    (wr_be),
         .d     (wr_data),
         .q     (shadow[i])
      );
      assign cfg_active[i*REG_WIDTH +: REG_WIDTH] = active[i];
   end

   assign cfg_mode    = active[0][MODE_BITS-1:0];
   assign commit_ack  = (state == COMMIT) && mode_ok;
   assign layer_start = (state == START);
   assign pending     = (state == WAIT);

   // Registered readback sees the pre-edge shadow, so a same-cycle write is not visible yet.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            if (!rd_in_range)      rd_data <= '0;
            else if (rd_sel_active) rd_data <= active[rd_addr];
            else                    rd_data <= shadow[rd_addr];
         end
         if (err_clr)
            addr_err <= 1'b0;
         else if ((wr_en && !wr_in_range) || (rd_en && !rd_in_range))
            addr_err <= 1'b1;
      end
   end

   // req_armed is consumed on entry to WAIT and only restored by commit_req going low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         req_armed <= 1'b1;
         cfg_valid <= 1'b0;
         mode_err  <= 1'b0;
         for (int r = 0; r < N_REGS; r++) active[r] <= '0;
      end else begin
         if (!commit_req) req_armed <= 1'b1;
         if (err_clr)     mode_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (commit_req && req_armed) begin
                  state     <= WAIT;
                  req_armed <= 1'b0;
               end
            end
            WAIT: begin
               if (!commit_req)      state <= IDLE;
               else if (engine_idle) state <= COMMIT;
            end
            COMMIT: begin
               if (mode_ok) begin
                  for (int r = 0; r < N_REGS; r++) active[r] <= shadow[r];
                  cfg_valid <= 1'b1;
                  state     <= START;
               end else begin
                  if (!err_clr) mode_err <= 1'b1;
                  state <= IDLE;
               end
            end
            START:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conf_reg_bank_db.sv
// tb/tb_conf_reg_bank_db.sv - self-checking bench for conf_reg_bank_db
module tb_conf_reg_bank_db;
   import conf_reg_bank_db_pkg::*;

   localparam int NR = 20;
   localparam int RW = 32;
   localparam int AW = 5;
   localparam int NM = 4;
   localparam int MB = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            wr_en = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [RW-1:0]   wr_data = '0;
   logic [RW/8-1:0] wr_be = '0;
   logic            rd_en = 1'b0;
   logic [AW-1:0]   rd_addr = '0;
   logic            rd_sel_active = 1'b0;
   logic [RW-1:0]   rd_data;
   logic            rd_valid;
   logic            commit_req = 1'b0;
   logic            engine_idle = 1'b0;
   logic            commit_ack;
   logic            layer_start;
   logic [NR*RW-1:0] cfg_active;
   logic [MB-1:0]   cfg_mode;
   logic            cfg_valid;
   logic            pending;
   logic            addr_err;
   logic            mode_err;
   logic            err_clr = 1'b0;

   conf_reg_bank_db #(.N_REGS(NR), .REG_WIDTH(RW), .ADDR_W(AW), .N_MODES(NM), .MODE_BITS(MB)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel_active(rd_sel_active), .rd_data(rd_data), .rd_valid(rd_valid),
      .commit_req(commit_req), .engine_idle(engine_idle), .commit_ack(commit_ack), .layer_start(layer_start),
      .cfg_active(cfg_active), .cfg_mode(cfg_mode), .cfg_valid(cfg_valid), .pending(pending),
      .addr_err(addr_err), .mode_err(mode_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] sh [NR];
   logic [31:0] ac [NR];

   typedef struct {
      int          addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = d[k*8 +: 8];
      return r;
   endfunction

   task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
      tick();
      wr_en = 1'b0;
      if (a < NR) sh[a] = merge(sh[a], d, be);
   endtask

   task automatic rd(input int a, input logic sel, output logic [31:0] data, output logic v);
      rd_en = 1'b1; rd_addr = AW'(a); rd_sel_active = sel;
      tick();
      data = rd_data; v = rd_valid;
      rd_en = 1'b0;
   endtask

   task automatic check_reg(input string name, input int a, input logic sel);
      logic [31:0] d;
      logic v;
      rd(a, sel, d, v);
      check({name, "_valid"}, v, 1'b1);
      check(name, d, sel ? ac[a] : sh[a]);
   endtask

   task automatic clear_model();
      for (int i = 0; i < NR; i++) begin
         sh[i] = '0;
         ac[i] = '0;
      end
   endtask

   initial begin
      logic [31:0] d;
      logic v;
      int acks;
      logic exp_aerr;
      logic exp_ok;
      logic [31:0] exp_rd;
      int a;

      vecs[0] = '{3,  32'hDEADBEEF, 4'b0101, 32'h00AD00EF};
      vecs[1] = '{3,  32'h11223344, 4'b1010, 32'h11AD33EF};
      vecs[2] = '{5,  32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
      vecs[3] = '{5,  32'h00000000, 4'b0001, 32'hCAFEF000};
      vecs[4] = '{19, 32'hFFFFFFFF, 4'b1000, 32'hFF000000};
      vecs[5] = '{19, 32'h12345678, 4'b0000, 32'hFF000000};

      clear_model();
      repeat (3) tick();
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_commit_ack", commit_ack, 0);
      check("rst_layer_start", layer_start, 0);
      check("rst_cfg_valid", cfg_valid, 0);
      check("rst_pending", pending, 0);
      check("rst_addr_err", addr_err, 0);
      check("rst_mode_err", mode_err, 0);
      check("rst_cfg_active", |cfg_active, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         wr(vecs[i].addr, vecs[i].data, vecs[i].be);
         rd(vecs[i].addr, 1'b0, d, v);
         check("vec_rd_valid", v, 1'b1);
         check($sformatf("vec%0d_shadow", i), d, vecs[i].exp);
      end
      rd(3, 1'b1, d, v);
      check("vec_active3", d, 32'h0);
      check("vec_cfg_valid", cfg_valid, 0);

      // commit of CNN mode after a 5-cycle busy engine
      wr(0, 32'h1, 4'hF);
      commit_req = 1'b1; engine_idle = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("wait_pending", pending, 1'b1);
         check("wait_no_ack", commit_ack, 1'b0);
      end
      engine_idle = 1'b1;
      tick();
      check("commit_ack", commit_ack, 1'b1);
      check("commit_no_start", layer_start, 1'b0);
      for (int i = 0; i < NR; i++) ac[i] = sh[i];
      tick();
      check("start_ack_low", commit_ack, 1'b0);
      check("layer_start", layer_start, 1'b1);
      check("cfg_mode_cnn", cfg_mode, MB'(MODE_CNN));
      check("cfg_valid_set", cfg_valid, 1'b1);
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (commit_ack) acks++;
      end
      check("held_req_single_ack", acks, 0);
      check("held_req_not_pending", pending, 1'b0);
      check_reg("active3_after_commit", 3, 1'b1);

      // illegal mode is rejected and flagged
      commit_req = 1'b0;
      tick();
      wr(0, 32'h5, 4'hF);
      commit_req = 1'b1; engine_idle = 1'b1;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (commit_ack || layer_start) acks++;
      end
      check("bad_mode_no_ack", acks, 0);
      check("bad_mode_err", mode_err, 1'b1);
      check("bad_mode_cfg_mode", cfg_mode, MB'(MODE_CNN));
      check_reg("bad_mode_active0", 0, 1'b1);
      err_clr = 1'b1; wr_en = 1'b1; wr_addr = AW'(21); wr_be = 4'hF;
      tick();
      err_clr = 1'b0; wr_en = 1'b0;
      check("err_clr_mode", mode_err, 1'b0);
      check("err_clr_priority", addr_err, 1'b0);
      commit_req = 1'b0;
      tick();

      // write landing in the COMMIT cycle stays in the shadow only
      wr(0, 32'h2, 4'hF);
      wr(7, 32'hAA, 4'hF);
      commit_req = 1'b1; engine_idle = 1'b1;
      tick();
      tick();
      check("sim_commit_ack", commit_ack, 1'b1);
      for (int i = 0; i < NR; i++) ac[i] = sh[i];
      wr(7, 32'h55, 4'hF);
      check("sim_layer_start", layer_start, 1'b1);
      rd(7, 1'b1, d, v);
      check("sim_active7", d, 32'hAA);
      rd(7, 1'b0, d, v);
      check("sim_shadow7", d, 32'h55);
      commit_req = 1'b0;
      tick();

      // out-of-range accesses
      wr(NR, 32'hFFFFFFFF, 4'hF);
      check("oor_wr_addr_err", addr_err, 1'b1);
      for (int i = 0; i < NR; i++) check_reg($sformatf("oor_shadow%0d", i), i, 1'b0);
      rd(25, 1'b0, d, v);
      check("oor_rd_data", d, 32'h0);
      check("oor_rd_valid", v, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("oor_cleared", addr_err, 1'b0);

      // reset while waiting for the engine aborts the commit
      commit_req = 1'b1; engine_idle = 1'b0;
      tick();
      check("rst_wait_pending", pending, 1'b1);
      reset = 1'b1; commit_req = 1'b0;
      tick();
      reset = 1'b0;
      clear_model();
      check("rstw_pending", pending, 0);
      check("rstw_cfg_valid", cfg_valid, 0);
      check("rstw_cfg_active", |cfg_active, 0);
      check("rstw_rd_valid", rd_valid, 0);
      engine_idle = 1'b1;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (commit_ack || layer_start) acks++;
      end
      check("rstw_no_ack", acks, 0);
      check_reg("rstw_shadow7", 7, 1'b0);

      // randomized writes/reads against the array model
      exp_aerr = 1'b0;
      for (int n = 0; n < 400; n++) begin
         wr_en = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 23);
         wr_addr = AW'(a);
         wr_data = $urandom;
         wr_be = 4'($urandom);
         rd_en = 1'($urandom_range(0, 1));
         rd_addr = AW'($urandom_range(0, 23));
         rd_sel_active = 1'($urandom_range(0, 1));
         err_clr = ($urandom_range(0, 15) == 0);
         if (int'(rd_addr) >= NR) exp_rd = '0;
         else exp_rd = rd_sel_active ? ac[rd_addr] : sh[rd_addr];
         if (err_clr) exp_aerr = 1'b0;
         else if ((wr_en && a >= NR) || (rd_en && int'(rd_addr) >= NR)) exp_aerr = 1'b1;
         if (wr_en && a < NR) sh[a] = merge(sh[a], wr_data, wr_be);
         tick();
         check("rnd_rd_valid", rd_valid, rd_en);
         if (rd_en) check("rnd_rd_data", rd_data, exp_rd);
         check("rnd_addr_err", addr_err, exp_aerr);
      end
      wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;

      exp_ok = (sh[0][MB-1:0] < NM);
      commit_req = 1'b1; engine_idle = 1'b1;
      tick();
      tick();
      check("rnd_commit_ack", commit_ack, exp_ok);
      if (exp_ok) for (int i = 0; i < NR; i++) ac[i] = sh[i];
      tick();
      check("rnd_layer_start", layer_start, exp_ok);
      check("rnd_mode_err", mode_err, !exp_ok);
      commit_req = 1'b0;
      for (int i = 0; i < NR; i++) check_reg($sformatf("rnd_active%0d", i), i, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conf_reg_bank_db.md
Name: conf_reg_bank_db

Overview:
- Double-buffered configuration register bank for the MAC engine; successor to the fixed 32-register configuration space.
- The host writes a shadow copy through the 32-bit external write port at any time. A commit handshake copies the shadow copy into the active copy only when the engine is idle, and then pulses layer_start.
- Register count, register width, byte-strobe granularity and legal mode count are parametrised. Adds readback, address/mode error flags and a commit-pending state.

Parameters:
- N_REGS, 32, number of configuration registers.
- REG_WIDTH, 32, bits per register; must be a multiple of 8.
- ADDR_W, $clog2(N_REGS), register address width.
- N_MODES, 4, legal mode codes 0..N_MODES-1 (FC=0, CNN=1, ACTIVATION=2, EWS=3).
- MODE_BITS, 2, width of the mode field in register 0, bits [MODE_BITS-1:0].

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- wr_en, in, 1, shadow write strobe.
- wr_addr, in, ADDR_W, shadow register index.
- wr_data, in, REG_WIDTH, write data.
- wr_be, in, REG_WIDTH/8, byte enables.
- rd_en, in, 1, readback request.
- rd_addr, in, ADDR_W, readback index.
- rd_sel_active, in, 1, 1 reads the active copy, 0 reads the shadow copy.
- rd_data, out, REG_WIDTH, readback data.
- rd_valid, out, 1, readback data valid.
- commit_req, in, 1, level request to commit shadow to active.
- engine_idle, in, 1, engine has no layer in flight.
- commit_ack, out, 1, one-cycle pulse when the copy happens.
- layer_start, out, 1, one-cycle pulse, the cycle after commit_ack.
- cfg_active, out, N_REGS*REG_WIDTH, active copy, flattened; register i occupies [i*REG_WIDTH +: REG_WIDTH].
- cfg_mode, out, MODE_BITS, active register 0 mode field.
- cfg_valid, out, 1, at least one successful commit has occurred since reset.
- pending, out, 1, FSM is in WAIT.
- addr_err, out, 1, sticky; set by a wr_en or rd_en with address >= N_REGS.
- mode_err, out, 1, sticky; set by a rejected commit.
- err_clr, in, 1, clears both sticky error flags.

Behaviour:
- Reset: every register in the shadow and active copies is 0. rd_data=0, rd_valid=0, commit_ack=0, layer_start=0, cfg_valid=0, pending=0, addr_err=0, mode_err=0. FSM goes to IDLE.
- Reset asserted mid-operation aborts any pending commit. No ack or start pulse is generated.
- Shadow write:
  - Takes effect on the clk edge where wr_en=1 and wr_addr<N_REGS.
  - Byte k is updated only when wr_be[k]=1.
  - Out-of-range address: write ignored, addr_err set.
- Readback:
  - 1-cycle latency: rd_en at cycle t gives rd_valid=1 and rd_data at cycle t+1.
  - Out-of-range address returns 0 with rd_valid=1 and sets addr_err.
  - A shadow read in the same cycle as a write to the same address returns the pre-write value.
- FSM states IDLE, WAIT, COMMIT, START:
  - IDLE -> WAIT when commit_req=1.
  - WAIT -> COMMIT when engine_idle=1. WAIT -> IDLE when commit_req drops before that (request withdrawn, no effect).
  - COMMIT: lasts one cycle. Copies shadow to active at the end of the cycle and drives commit_ack=1. If the shadow mode field >= N_MODES, the copy is suppressed, commit_ack=0 and mode_err is set. Goes to START only if the copy was accepted, otherwise to IDLE.
  - START: lasts one cycle; layer_start=1, cfg_valid set. Goes to IDLE.
  - Re-arming requires commit_req to be deasserted and then reasserted, giving at most one commit per request level. FSM tracks the previous value of commit_req for this.
- Simultaneous write and COMMIT: the active copy receives the pre-write shadow value. The write lands in the shadow copy only.
- The active copy never changes outside COMMIT, so the engine sees stable configuration for the whole layer.
- err_clr has priority over a new error set in the same cycle.
- commit_ack and layer_start are never high together.
- Latency from engine_idle rising while in WAIT: commit_ack +1 cycle, layer_start +2 cycles.

Decomposition:
- Shared package gets:
  - the MODE_FC/CNN/ACTIVATION/EWS constants;
  - the FSM state enum (IDLE, WAIT, COMMIT, START);
  - the N_REGS and REG_WIDTH defaults, tied to CONF_REGISTERS_SIZE and BIT_WIDTH_EXTERNAL_PORT.
- One sub-module, byte_strobe_reg: a REG_WIDTH register with per-byte enable and synchronous reset, instantiated N_REGS times for the shadow copy.
- The active copy and the FSM live in the top module.

Test Plan:
- Reset, then write reg 3 = 0xDEADBEEF with wr_be=4'b0101 -> shadow readback of reg 3 = 0x00AD00EF after 1 cycle; active readback of reg 3 = 0; cfg_valid=0.
- Write reg 0 = 0x1 (CNN), commit_req=1, engine_idle=0 for 5 cycles, then 1 -> pending=1 during the wait; commit_ack exactly 1 cycle after idle rises; layer_start on the next cycle; cfg_mode=1; cfg_valid=1.
- Shadow reg 0 mode = 5 with N_MODES=4, commit with engine_idle=1 -> no commit_ack, mode_err=1, active reg 0 unchanged; err_clr -> mode_err=0.
- Write reg 7 = 0x55 in the same cycle as COMMIT, with shadow reg 7 = 0xAA beforehand -> active reg 7 = 0xAA, shadow reg 7 = 0x55.
- wr_addr = N_REGS with N_REGS=20 -> no register changes, addr_err=1; rd_addr = 25 -> rd_data=0, rd_valid=1.
- commit_req held high across two idle windows -> exactly one commit_ack. Assert reset while in WAIT -> FSM returns to IDLE, no ack, all outputs at their reset values.
